ym_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer that replaces the single-cycle PC/control path of the lab CPU. It owns the PC and instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It adds ready-handshaked instruction and data memory ports, a parametrised reset entry point, an illegal-opcode trap and a retired-instruction counter. Register file, ALU and data memory stay external and are steered by the control outputs.

---
 rtl/ym_multicycle_ctrl_pkg.sv | 37 +++
 rtl/ym_multicycle_ctrl_if.sv | 28 ++
 rtl/ym_multicycle_ctrl_decode.sv | 23 ++
 rtl/ym_multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ym_multicycle_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ym_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states,
// ALU operation codes and the decoded-instruction bundle.
package ym_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_jal;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/ym_multicycle_ctrl_if.sv
// Instruction and data memory handshake bundle between the sequencer
// (master) and the memories (slave).
interface ym_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready
  );
endinterface

// File: rtl/ym_multicycle_ctrl_decode.sv
// Combinational opcode classifier; anything outside the supported set is
// flagged illegal.
module ym_decode
  import ym_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_R:    dec.is_r    = 1'b1;
      OP_I:    dec.is_i    = 1'b1;
      OP_LW:   dec.is_lw   = 1'b1;
      OP_SW:   dec.is_sw   = 1'b1;
      OP_BEQ:  dec.is_beq  = 1'b1;
      OP_JAL:  dec.is_jal  = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ym_multicycle_ctrl.sv
// Multi-cycle PC/IR sequencer with handshaked memories, illegal-opcode trap
// and a wrapping retired-instruction counter.
//   state  | meaning
//   FETCH  | imem_req high, latch IR on imem_ready
//   DECODE | classify IR, illegal opcode goes to TRAP
//   EXEC   | ALU steering; BEQ/JAL update PC and retire here
//   MEM    | dmem_req high until dmem_ready; SW retires here
//   WB     | register write, PC+4, retire
//   TRAP   | everything frozen until reset
module ym_multicycle_ctrl
  import ym_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int unsigned ENTRY_POINT = 128,
  parameter int          CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ym_multicycle_ctrl_if.master  bus,
  output logic [XLEN-1:0]       pc,
  output logic [31:0]           ir,
  input  logic                  zero,
  input  logic [XLEN-1:0]       branch_target,
  input  logic [XLEN-1:0]       jump_target,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic [1:0]            alu_op,
  output logic                  mem2reg,
  output logic                  link_sel,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      retired,
  output logic                  trap
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_TRAP   = ST_TRAP;

  logic [2:0]       state_q,   state_d;
  logic [XLEN-1:0]  pc_q,      pc_d;
  logic [31:0]      ir_q,      ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_q,    trap_d;
  logic [XLEN-1:0]  pc_inc;
  logic             retire;
  dec_t             dec;

  ym_decode u_decode (
    .opcode (ir_q[6:0]),
    .dec    (dec)
  );

  assign pc_inc = pc_q + XLEN'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    trap_d    = trap_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec.is_r || dec.is_i) begin
          state_d = S_WB;
        end else if (dec.is_lw || dec.is_sw) begin
          state_d = S_MEM;
        end else if (dec.is_beq) begin
          pc_d    = zero ? branch_target : pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (dec.is_jal) begin
          pc_d    = jump_target;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (dec.is_sw) begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= XLEN'(ENTRY_POINT);
      ir_q      <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  // ALU steering is held through MEM and WB so the address and the R/I
  // result stay valid while memory and the register file consume them.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    alu_op       = ALU_ADD;
    mem2reg      = 1'b0;
    link_sel     = 1'b0;
    case (state_q)
      S_FETCH: bus.imem_req = 1'b1;
      S_EXEC: begin
        if (dec.is_r) begin
          alu_op = ALU_FUNCT;
        end else if (dec.is_i) begin
          alu_op  = ALU_FUNCT;
          alu_src = 1'b1;
        end else if (dec.is_lw || dec.is_sw) begin
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
        end else if (dec.is_beq) begin
          alu_op = ALU_SUB;
        end else if (dec.is_jal) begin
          reg_write = 1'b1;
          link_sel  = 1'b1;
        end
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = dec.is_sw;
        alu_src      = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = dec.is_lw;
        if (dec.is_r || dec.is_i) begin
          alu_op  = ALU_FUNCT;
          alu_src = dec.is_i;
        end else begin
          alu_src = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign state   = state_q;
  assign retired = retired_q;
  assign trap    = trap_q;

endmodule

// File: tb/tb_ym_multicycle_ctrl.sv
// Self-checking bench for ym_multicycle_ctrl: directed vector table, random
// instruction stream against an instruction-level model, and corner sequences.
module tb_ym_multicycle_ctrl;

  localparam int XLEN  = 32;
  localparam int EP    = 128;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ym_multicycle_ctrl_if bus();

  logic [XLEN-1:0]  pc, branch_target, jump_target;
  logic [31:0]      ir;
  logic             zero, reg_write, alu_src, mem2reg, link_sel, trap;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  ym_multicycle_ctrl #(.XLEN(XLEN), .ENTRY_POINT(EP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pc(pc), .ir(ir), .zero(zero),
    .branch_target(branch_target), .jump_target(jump_target),
    .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem2reg(mem2reg), .link_sel(link_sel), .state(state),
    .retired(retired), .trap(trap)
  );

  typedef enum {C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_BAD} cls_e;

  typedef struct {
    logic [31:0] instr;
    int          wi;
    int          wd;
    logic        z;
    logic [31:0] tgt;
    int          exp_cyc;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  int          m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cls_e classify(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b1100011: return C_BEQ;
      7'b1101111: return C_JAL;
      default:    return C_BAD;
    endcase
  endfunction

  function automatic int base_cycles(input cls_e c);
    if (c == C_BEQ || c == C_JAL) return 3;
    if (c == C_LW) return 5;
    return 4;
  endfunction

  task automatic drive_idle();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0;
    zero = 1'b0;
    branch_target = '0;
    jump_target = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc  = EP;
    m_ret = 0;
  endtask

  // One instruction from FETCH to retire; memories respond after wi/wd wait cycles
  // and inject noise on ready/rdata whenever they are not being requested.
  task automatic run_instr(input logic [31:0] instr, input int wi, input int wd,
                           input logic z, input logic [31:0] tgt,
                           input int exp_cyc, input logic [31:0] exp_pc, input string nm);
    cls_e        c;
    int          rw, m2r, lnk, dreq, dwe, wi_l, wd_l, exec_cyc;
    bit          early;
    logic [1:0]  op_ex;
    logic        src_ex;
    logic [31:0] pc0;
    logic [CNT_W-1:0] ret0;
    c = classify(instr);
    rw = 0; m2r = 0; lnk = 0; dreq = 0; dwe = 0;
    wi_l = wi; wd_l = wd; exec_cyc = wi + 3; early = 1'b0;
    op_ex = 2'b11; src_ex = 1'bx;
    pc0 = pc; ret0 = retired;
    zero = z;
    branch_target = (c == C_JAL) ? $urandom : tgt;
    jump_target   = (c == C_JAL) ? tgt : $urandom;
    for (int k = 1; k <= exp_cyc; k++) begin
      rw  += int'(reg_write);
      m2r += int'(mem2reg);
      lnk += int'(link_sel);
      dreq += int'(bus.dmem_req);
      dwe  += int'(bus.dmem_req & bus.dmem_we);
      if (k == exec_cyc) begin
        op_ex  = alu_op;
        src_ex = alu_src;
      end
      if (bus.imem_req) begin
        bus.imem_ready = (wi_l == 0);
        if (wi_l > 0) wi_l--;
        bus.imem_rdata = bus.imem_ready ? instr : $urandom;
      end else begin
        bus.imem_ready = 1'($urandom);
        bus.imem_rdata = $urandom;
      end
      if (bus.dmem_req) begin
        bus.dmem_ready = (wd_l == 0);
        if (wd_l > 0) wd_l--;
      end else begin
        bus.dmem_ready = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (k < exp_cyc && (retired !== ret0 || pc !== pc0)) early = 1'b1;
    end
    m_pc  = exp_pc;
    m_ret = (m_ret + 1) % (1 << CNT_W);
    chk({nm, "_pc"}, 64'(pc), 64'(exp_pc));
    chk({nm, "_retired"}, 64'(retired), 64'(m_ret));
    chk({nm, "_no_early_update"}, 64'(early), 64'(0));
    chk({nm, "_back_in_fetch"}, 64'({state, bus.imem_req}), 64'({3'd0, 1'b1}));
    chk({nm, "_ir"}, 64'(ir), 64'(instr));
    chk({nm, "_reg_write_cycles"}, 64'(rw),
        64'((c == C_R || c == C_I || c == C_LW || c == C_JAL) ? 1 : 0));
    chk({nm, "_mem2reg_cycles"}, 64'(m2r), 64'((c == C_LW) ? 1 : 0));
    chk({nm, "_link_sel_cycles"}, 64'(lnk), 64'((c == C_JAL) ? 1 : 0));
    chk({nm, "_dmem_req_cycles"}, 64'(dreq), 64'((c == C_LW || c == C_SW) ? wd + 1 : 0));
    chk({nm, "_dmem_we_cycles"}, 64'(dwe), 64'((c == C_SW) ? wd + 1 : 0));
    chk({nm, "_exec_alu_op"}, 64'(op_ex),
        64'((c == C_R || c == C_I) ? 2 : (c == C_BEQ) ? 1 : 0));
    chk({nm, "_exec_alu_src"}, 64'(src_ex),
        64'((c == C_I || c == C_LW || c == C_SW) ? 1 : 0));
  endtask

  vec_t        tbl[7];
  bit          frozen_ok;
  logic [31:0] instr, tgt;
  logic        z;
  int          wi, wd, ncyc;
  cls_e        c;
  logic [6:0]  ops[6];

  initial begin
    tbl[0] = '{32'h002081B3, 0, 0, 1'b0, 32'h0,   4, 32'd132};  // add
    tbl[1] = '{32'h0000A183, 0, 2, 1'b0, 32'h0,   7, 32'd136};  // lw, 2 data waits
    tbl[2] = '{32'h00208463, 0, 0, 1'b1, 32'd200, 3, 32'd200};  // beq taken
    tbl[3] = '{32'h00208463, 0, 0, 1'b0, 32'd300, 3, 32'd204};  // beq not taken
    tbl[4] = '{32'h0020A223, 1, 1, 1'b0, 32'h0,   6, 32'd208};  // sw, 1+1 waits
    tbl[5] = '{32'h00108093, 2, 0, 1'b1, 32'h0,   6, 32'd212};  // addi, 2 fetch waits
    tbl[6] = '{32'h008000EF, 0, 0, 1'b0, 32'h400, 3, 32'h400};  // jal
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

    do_reset();
    chk("reset_pc", 64'(pc), 64'(EP));
    chk("reset_state", 64'(state), 64'(0));
    chk("reset_imem_req", 64'(bus.imem_req), 64'(1));
    chk("reset_retired", 64'(retired), 64'(0));
    chk("reset_trap", 64'(trap), 64'(0));
    chk("reset_ir", 64'(ir), 64'(0));
    chk("reset_strobes", 64'({bus.dmem_req, bus.dmem_we, reg_write, mem2reg, link_sel}), 64'(0));

    for (int i = 0; i < 7; i++)
      run_instr(tbl[i].instr, tbl[i].wi, tbl[i].wd, tbl[i].z, tbl[i].tgt,
                tbl[i].exp_cyc, tbl[i].exp_pc, $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      instr = {$urandom} & 32'hFFFF_FF80;
      instr[6:0] = ops[$urandom_range(0, 5)];
      c   = classify(instr);
      wi  = $urandom_range(0, 3);
      wd  = $urandom_range(0, 3);
      z   = 1'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      ncyc = base_cycles(c) + wi + ((c == C_LW || c == C_SW) ? wd : 0);
      run_instr(instr, wi, wd, z, tgt, ncyc,
                (c == C_JAL) ? tgt : (c == C_BEQ && z) ? tgt : m_pc + 32'd4,
                $sformatf("rnd%0d", i));
    end

    // pc+4 must wrap modulo 2^XLEN
    run_instr(32'h008000EF, 0, 0, 1'b0, 32'hFFFF_FFFC, 3, 32'hFFFF_FFFC, "jal_top");
    run_instr(32'h002081B3, 0, 0, 1'b0, 32'h0, 4, 32'h0, "add_wrap_pc");

    // 17 back-to-back JALs through a 4-bit counter: 15 -> 0 -> 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      run_instr(32'h008000EF, 0, 0, 1'b0, tgt, 3, tgt, $sformatf("jal%0d", i));
      if (i == 14) chk("wrap_at_15", 64'(retired), 64'(15));
      if (i == 15) chk("wrap_to_0", 64'(retired), 64'(0));
    end
    chk("wrap_to_1", 64'(retired), 64'(1));

    // illegal opcode: trap from DECODE, then frozen until reset
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000007F;
    @(posedge clk); #1;
    chk("trap_decode_state", 64'(state), 64'(1));
    bus.imem_rdata = $urandom;
    @(posedge clk); #1;
    chk("trap_state", 64'(state), 64'(5));
    chk("trap_flag", 64'(trap), 64'(1));
    frozen_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ready = 1'($urandom);
      bus.imem_rdata = $urandom;
      bus.dmem_ready = 1'($urandom);
      zero = 1'($urandom);
      branch_target = $urandom;
      jump_target = $urandom;
      @(posedge clk); #1;
      if (pc !== m_pc || retired !== CNT_W'(m_ret) || state !== 3'd5 || trap !== 1'b1 ||
          {bus.imem_req, bus.dmem_req, bus.dmem_we, reg_write, mem2reg, link_sel} !== 6'b0)
        frozen_ok = 1'b0;
    end
    chk("trap_frozen_20", 64'(frozen_ok), 64'(1));
    do_reset();
    chk("trap_exit_pc", 64'(pc), 64'(EP));
    chk("trap_exit_flag", 64'(trap), 64'(0));
    chk("trap_exit_state", 64'(state), 64'(0));

    // reset in MEM of a store with dmem_ready: abandoned, never retired
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0020A223;
    @(posedge clk); #1;
    bus.imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sw_in_mem", 64'({state, bus.dmem_req, bus.dmem_we}), 64'({3'd3, 1'b1, 1'b1}));
    bus.dmem_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.dmem_ready = 1'b0;
    chk("rst_mem_pc", 64'(pc), 64'(EP));
    chk("rst_mem_retired", 64'(retired), 64'(0));
    chk("rst_mem_state", 64'(state), 64'(0));
    m_pc = EP;
    m_ret = 0;
    run_instr(32'h002081B3, 0, 0, 1'b0, 32'h0, 4, 32'd132, "restart_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
